// File: rtl/cam_row_stream.sv
// cam_row_stream: row-wise LOAD/STORE front end between valid/ready streams and the CAM cell array.
// Latency: a LOAD beat is written to its row in the cycle after acceptance; STORE readback reaches the skid FIFO two cycles after issue.
// Backpressure: s_ready drops once the LOAD count is met; STORE issue throttles on FIFO space, and m_valid/m_data hold while m_ready=0.

// Small skid FIFO holding row readback words until the output stream takes them.
// Latency: a pushed word is visible at head on the following cycle.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module cam_row_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module cam_row_stream #(
    parameter int       DATA_WIDTH     = 4,
    parameter int       DATA_DEPTH     = 4,
    parameter int       ADDR_WIDTH_CAM = 8,
    parameter int       FIFO_DEPTH     = 4,
    parameter logic [2:0] RowxRow      = 3'd1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_load,
    input  logic                      start_store,
    input  logic [ADDR_WIDTH_CAM-1:0] base_row,
    input  logic [ADDR_WIDTH_CAM-1:0] row_count,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2:0]                input_mode,
    output logic [ADDR_WIDTH_CAM-1:0] addr_input_Row,
    output logic [DATA_WIDTH-1:0]     Ip_row,
    output logic                      wr_n,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
    input  logic [DATA_WIDTH-1:0]     Q_out_row,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH_CAM-1:0] ADDR_OFF = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
    localparam logic [ADDR_WIDTH_CAM-1:0] LAST_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH_CAM-1:0] ONE      = ADDR_WIDTH_CAM'(1);
    localparam logic [ADDR_WIDTH_CAM:0]   DEPTH_X  = (ADDR_WIDTH_CAM + 1)'(DATA_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_FIN
    } state_t;

    state_t                    state;
    logic [ADDR_WIDTH_CAM-1:0] total;
    logic [ADDR_WIDTH_CAM-1:0] cur_row;
    logic [ADDR_WIDTH_CAM-1:0] iss_cnt;
    logic [ADDR_WIDTH_CAM-1:0] pop_cnt;

    // Readback pipe: pipe_v0 = address presented to the array, pipe_v1 = Q_out_row valid now.
    logic                      pipe_v0;
    logic                      pipe_v1;

    logic [CW-1:0]             fifo_cnt;
    logic [CW-1:0]             fifo_free;
    logic [CW-1:0]             in_flight;
    logic [DATA_WIDTH-1:0]     fifo_head;
    logic                      can_issue;
    logic                      pop;
    logic                      bad_args;

    function automatic logic [ADDR_WIDTH_CAM-1:0] next_row(input logic [ADDR_WIDTH_CAM-1:0] r);
        return (r == LAST_ROW) ? '0 : r + ONE;
    endfunction

    assign bad_args  = ({1'b0, row_count} > DEPTH_X) || ({1'b0, base_row} >= DEPTH_X);

    // A new read is issued only if every word already in the pipe still has a slot waiting.
    assign fifo_free = CW'(FIFO_DEPTH) - fifo_cnt;
    assign in_flight = CW'(pipe_v0) + CW'(pipe_v1);
    assign can_issue = (state == ST_STORE) && (iss_cnt != total) && (fifo_free > in_flight);

    // Output is the FIFO head, driven from registers only, forced to zero when not valid.
    assign m_valid   = (state == ST_STORE) && (fifo_cnt != '0);
    assign m_data    = m_valid ? fifo_head : '0;
    assign pop       = m_valid && m_ready;

    cam_row_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_v1),
        .push_data (Q_out_row),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    // Track which array reads are in flight so their returning data is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v0 <= 1'b0;
            pipe_v1 <= 1'b0;
        end else begin
            pipe_v0 <= can_issue;
            pipe_v1 <= pipe_v0;
        end
    end

    // Transfer FSM with registered array-side controls and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            s_ready         <= 1'b0;
            input_mode      <= 3'd0;
            addr_input_Row  <= '0;
            Ip_row          <= '0;
            wr_n            <= 1'b1;
            addr_output_Row <= ADDR_OFF;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            total           <= '0;
            cur_row         <= '0;
            iss_cnt         <= '0;
            pop_cnt         <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            wr_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_load || start_store) begin
                        if (bad_args) begin
                            err <= 1'b1;
                        end else if (row_count == '0) begin
                            state      <= ST_FIN;
                            done       <= 1'b1;
                            busy       <= 1'b1;
                            input_mode <= RowxRow;
                        end else begin
                            total      <= row_count;
                            cur_row    <= base_row;
                            iss_cnt    <= '0;
                            pop_cnt    <= '0;
                            busy       <= 1'b1;
                            input_mode <= RowxRow;
                            if (start_load) begin
                                state   <= ST_LOAD;
                                s_ready <= 1'b1;
                            end else begin
                                state   <= ST_STORE;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (s_valid && s_ready) begin
                        addr_input_Row <= cur_row;
                        Ip_row         <= s_data;
                        wr_n           <= 1'b0;
                        cur_row        <= next_row(cur_row);
                        iss_cnt        <= iss_cnt + ONE;
                        if (iss_cnt + ONE == total) begin
                            s_ready <= 1'b0;
                        end
                    end else if (!s_ready) begin
                        // s_ready only drops after the last beat, so this is the final write cycle.
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_STORE: begin
                    addr_output_Row <= can_issue ? cur_row : ADDR_OFF;
                    if (can_issue) begin
                        cur_row <= next_row(cur_row);
                        iss_cnt <= iss_cnt + ONE;
                    end
                    if (pop) begin
                        pop_cnt <= pop_cnt + ONE;
                        if (pop_cnt + ONE == total) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state           <= ST_IDLE;
                    busy            <= 1'b0;
                    input_mode      <= 3'd0;
                    addr_output_Row <= ADDR_OFF;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_row_stream.sv
// tb_cam_row_stream: scoreboard bench for cam_row_stream with a behavioural CAM array and reference row image.
// Latency: expectations are queued at start time and consumed by an independent negedge monitor.
// Backpressure: m_ready is driven constant, held, or randomized; s_valid is driven with random gaps.
module tb_cam_row_stream;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_load = 1'b0;
    logic       start_store = 1'b0;
    logic [7:0] base_row = '0;
    logic [7:0] row_count = '0;
    logic [3:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] input_mode;
    logic [7:0] addr_input_Row;
    logic [3:0] Ip_row;
    logic       wr_n;
    logic [7:0] addr_output_Row;
    logic [3:0] Q_out_row;
    logic       busy;
    logic       done;
    logic       err;

    int         vectors = 0;
    int         miscompares = 0;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_out[$];
    int          exp_done = 0;
    int          exp_err = 0;
    int          seen_done = 0;
    int          seen_err = 0;
    logic [3:0]  ref_mem [4];
    logic [3:0]  arr [4];
    logic [3:0]  ld_data [8];
    int          mr_mode = 0;
    logic        mr_hold = 1'b1;

    cam_row_stream dut (
        .clk             (clk),
        .rst             (rst),
        .start_load      (start_load),
        .start_store     (start_store),
        .base_row        (base_row),
        .row_count       (row_count),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .input_mode      (input_mode),
        .addr_input_Row  (addr_input_Row),
        .Ip_row          (Ip_row),
        .wr_n            (wr_n),
        .addr_output_Row (addr_output_Row),
        .Q_out_row       (Q_out_row),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Behavioural cell array: write on wr_n low, registered row readout.
    always @(posedge clk) begin
        if (!wr_n && addr_input_Row < 8'd4) arr[addr_input_Row[1:0]] <= Ip_row;
        if (addr_output_Row < 8'd4) Q_out_row <= arr[addr_output_Row[1:0]];
        else Q_out_row <= 4'd0;
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = follow mr_hold.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (mr_mode == 1) m_ready = 1'($urandom_range(0, 1));
            else if (mr_mode == 2) m_ready = mr_hold;
            else m_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consume expected writes/outputs/pulses as the DUT produces them.
    initial begin
        logic       hold_prev;
        logic [3:0] hold_data;
        logic [11:0] ew;
        logic [3:0]  eo;
        hold_prev = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (!wr_n) begin
                    check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
                    check("input_mode_on_write", 32'(input_mode), 32'd1);
                    if (exp_wr.size() > 0) begin
                        ew = exp_wr.pop_front();
                        check("write_row", 32'(addr_input_Row), 32'(ew[11:4]));
                        check("write_data", 32'(Ip_row), 32'(ew[3:0]));
                    end
                end
                if (hold_prev) begin
                    check("m_valid_held", 32'(m_valid), 32'd1);
                    check("m_data_held", 32'(m_data), 32'(hold_data));
                end
                if (m_valid && m_ready) begin
                    check("output_expected", 32'(exp_out.size() > 0), 32'd1);
                    if (exp_out.size() > 0) begin
                        eo = exp_out.pop_front();
                        check("m_data", 32'(m_data), 32'(eo));
                    end
                end
                if (s_ready || m_valid) check("s_ready_m_valid_exclusive", 32'(s_ready && m_valid), 32'd0);
                hold_prev = m_valid && !m_ready;
                hold_data = m_data;
                if (done) begin
                    seen_done++;
                    check("done_expected", 32'(seen_done <= exp_done), 32'd1);
                end
                if (err) begin
                    seen_err++;
                    check("err_expected", 32'(seen_err <= exp_err), 32'd1);
                end
            end
        end
    end

    // Queue expectations from the row-sequence rules, then pulse the start inputs.
    task automatic start_pulse(input bit ld, input bit st, input int base, input int cnt);
        int row;
        if (cnt > 4 || base >= 4) begin
            exp_err++;
        end else if (cnt == 0) begin
            exp_done++;
        end else begin
            exp_done++;
            for (int k = 0; k < cnt; k++) begin
                row = (base + k) % 4;
                if (ld) begin
                    exp_wr.push_back({8'(row), ld_data[k]});
                    ref_mem[row] = ld_data[k];
                end else begin
                    exp_out.push_back(ref_mem[row]);
                end
            end
        end
        start_load  = ld;
        start_store = st;
        base_row    = 8'(base);
        row_count   = 8'(cnt);
        @(posedge clk); #1;
        start_load  = 1'b0;
        start_store = 1'b0;
        base_row    = 8'($urandom);
        row_count   = 8'($urandom);
    endtask

    task automatic feed_load(input int cnt, input bit gaps, input bit poke);
        bit acc;
        int tmo;
        for (int k = 0; k < cnt; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_data = 4'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_data  = ld_data[k];
            s_valid = 1'b1;
            if (poke && k == 1) start_store = 1'b1;
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 50) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
                start_store = 1'b0;
                tmo++;
            end
            check("load_beat_accepted", 32'(acc), 32'd1);
            s_valid = 1'b0;
            s_data  = 4'($urandom);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_outputs", 32'(exp_out.size()), 32'd0);
        check("done_count", 32'(seen_done), 32'(exp_done));
        check("err_count", 32'(seen_err), 32'(exp_err));
    endtask

    task automatic check_array();
        for (int r = 0; r < 4; r++) check("array_row", 32'(arr[r]), 32'(ref_mem[r]));
    endtask

    task automatic do_op(input bit ld, input bit st, input int base, input int cnt,
                         input bit gaps, input bit poke);
        bit bad;
        bad = (cnt > 4) || (base >= 4);
        for (int k = 0; k < 8; k++) ld_data[k] = 4'($urandom);
        start_pulse(ld, st, base, cnt);
        if (ld && !bad && cnt > 0) feed_load(cnt, gaps, poke);
        wait_idle(300);
        settle();
        if (ld && !bad && cnt > 0) check_array();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_wr.delete();
        exp_out.delete();
        @(posedge clk); #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_input_mode", 32'(input_mode), 32'd0);
        check("rst_addr_input_Row", 32'(addr_input_Row), 32'd0);
        check("rst_Ip_row", 32'(Ip_row), 32'd0);
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_addr_output_Row", 32'(addr_output_Row), 32'd7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        exp_done = seen_done;
        exp_err  = seen_err;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int op, base, cnt;
        for (int r = 0; r < 4; r++) ref_mem[r] = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Initialise every row so later readbacks have known contents.
        do_op(1, 0, 0, 4, 0, 0);

        // Basic load of rows 1..3.
        do_op(1, 0, 1, 3, 0, 0);

        // Wrap: rows 3,0,1 written then read back in the same order.
        do_op(1, 0, 3, 3, 0, 0);
        do_op(0, 1, 3, 3, 0, 0);

        // Backpressure: stall the output 6 cycles, then drain all 4 rows.
        mr_mode = 2;
        mr_hold = 1'b0;
        start_pulse(0, 1, 0, 4);
        repeat (6) begin
            @(posedge clk); #1;
        end
        mr_hold = 1'b1;
        wait_idle(300);
        settle();
        mr_mode = 0;

        // Reset mid-STORE with words sitting in the FIFO.
        mr_mode = 2;
        mr_hold = 1'b0;
        start_pulse(0, 1, 1, 4);
        repeat (5) begin
            @(posedge clk); #1;
        end
        do_reset();
        mr_mode = 0;
        settle();

        // Errors and the empty transfer.
        do_op(0, 1, 0, 5, 0, 0);
        do_op(1, 0, 4, 2, 0, 0);
        start_pulse(1, 0, 2, 0);
        @(negedge clk);
        check("zero_count_done", 32'(done), 32'd1);
        wait_idle(50);
        settle();

        // Collision: both starts run LOAD; a store pulse during LOAD is ignored.
        do_op(1, 1, 0, 3, 0, 0);
        do_op(1, 0, 1, 2, 0, 1);
        do_op(0, 1, 0, 4, 0, 0);

        // Randomized mix of transfers with random flow control.
        mr_mode = 1;
        for (int i = 0; i < 30; i++) begin
            op   = $urandom_range(0, 9);
            base = $urandom_range(0, 3);
            cnt  = $urandom_range(1, 4);
            if (op == 8) begin
                if ($urandom_range(0, 1) == 1) cnt = $urandom_range(5, 7);
                else base = $urandom_range(4, 6);
                do_op(0, 1, base, cnt, 0, 0);
            end else if (op == 9) begin
                do_op(1, 0, base, 0, 0, 0);
            end else if (op < 4) begin
                do_op(1, 0, base, cnt, 1'($urandom_range(0, 1)), 0);
            end else begin
                do_op(0, 1, base, cnt, 0, 0);
            end
        end
        mr_mode = 0;
        do_op(0, 1, 0, 4, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
